// File: rtl/uart_line_echo.sv
// Line-buffered UART echo: collects received bytes until CR, then replays the
// line (plus '!' if it overflowed) followed by CR LF through a busy-gated transmitter.
module uart_line_echo #(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_READY,
  input  logic [7:0]               RX_DATA,
  output logic                     READY_CLR,
  input  logic                     TX_BUSY,
  output logic [7:0]               TX_DATA,
  output logic                     WR_EN,
  output logic [$clog2(DEPTH):0]   LINE_LEN,
  output logic                     OVERFLOW,
  output logic                     BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = AW + 2;

  typedef enum logic [2:0] {
    COLLECT,
    LOAD,
    STROBE,
    GUARD,
    DRAIN
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [7:0]     line_buf [DEPTH];
  logic [LW-1:0]  line_len;
  logic           overflow;
  logic           rx_hold;
  logic [IW-1:0]  tx_idx;
  logic [IW-1:0]  last_idx;
  logic [IW-1:0]  tail_idx;
  logic [7:0]     tx_data_q;
  logic [7:0]     seq_byte;
  logic           capture;
  logic           is_cr;
  logic           is_lf;
  logic           line_full;

  // rx_hold blocks a second consume until the receiver has been seen idle
  assign capture   = (state == COLLECT) && RX_READY && !rx_hold && !RST;
  assign is_cr     = (RX_DATA == 8'h0D);
  assign is_lf     = (RX_DATA == 8'h0A);
  assign line_full = (line_len == LW'(DEPTH));
  assign last_idx  = IW'(line_len) + IW'(overflow) + IW'(1);

  // Byte at transmit position tx_idx: buffered data, optional '!', CR, LF
  always_comb begin
    seq_byte = 8'h0A;
    tail_idx = tx_idx - IW'(line_len);
    if (tx_idx < IW'(line_len)) begin
      seq_byte = line_buf[tx_idx[AW-1:0]];
    end else if (overflow && (tail_idx == '0)) begin
      seq_byte = 8'h21;
    end else if (tail_idx == IW'(overflow)) begin
      seq_byte = 8'h0D;
    end else begin
      seq_byte = 8'h0A;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (capture && is_cr) state_next = LOAD;
      LOAD:    if (!TX_BUSY) state_next = STROBE;
      STROBE:  state_next = GUARD;
      GUARD:   state_next = DRAIN;
      DRAIN: begin
        if (!TX_BUSY) state_next = (tx_idx == last_idx) ? COLLECT : LOAD;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= COLLECT;
      line_len  <= '0;
      overflow  <= 1'b0;
      rx_hold   <= 1'b0;
      tx_idx    <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state <= state_next;
      if (capture) begin
        rx_hold <= 1'b1;
      end else if (!RX_READY) begin
        rx_hold <= 1'b0;
      end
      if (capture) begin
        if (is_cr) begin
          tx_idx <= '0;
        end else if (!is_lf) begin
          if (line_full) overflow <= 1'b1;
          else           line_len <= line_len + LW'(1);
        end
      end
      if (state == LOAD) tx_data_q <= seq_byte;
      if ((state == DRAIN) && !TX_BUSY) begin
        if (tx_idx == last_idx) begin
          line_len <= '0;
          overflow <= 1'b0;
        end else begin
          tx_idx <= tx_idx + IW'(1);
        end
      end
    end
  end

  // Line storage is not reset; a stale buffer is never read past line_len
  always_ff @(posedge CLK) begin
    if (capture && !is_cr && !is_lf && !line_full) begin
      line_buf[line_len[AW-1:0]] <= RX_DATA;
    end
  end

  assign READY_CLR = capture;
  assign WR_EN     = (state == STROBE);
  assign TX_DATA   = (state == LOAD) ? seq_byte : tx_data_q;
  assign LINE_LEN  = line_len;
  assign OVERFLOW  = overflow;
  assign BUSY      = (state != COLLECT);

endmodule

// File: tb/tb_uart_line_echo.sv
// Bench for uart_line_echo: models receiver handshake and a transmitter that
// stays busy 10 cycles per strobe; expected bytes flow through a scoreboard queue.
module tb_uart_line_echo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          RST;
  logic          RX_READY;
  logic [7:0]    RX_DATA;
  logic          READY_CLR;
  logic          TX_BUSY;
  logic [7:0]    TX_DATA;
  logic          WR_EN;
  logic [LW-1:0] LINE_LEN;
  logic          OVERFLOW;
  logic          BUSY;

  int            checks;
  int            errors;
  int            wr_count;
  int            rc_count;
  int            tx_cnt;
  logic          tx_force;
  logic          prev_wr;
  logic          prev_busy;
  logic [7:0]    exp_q[$];

  uart_line_echo #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_READY  (RX_READY),
    .RX_DATA   (RX_DATA),
    .READY_CLR (READY_CLR),
    .TX_BUSY   (TX_BUSY),
    .TX_DATA   (TX_DATA),
    .WR_EN     (WR_EN),
    .LINE_LEN  (LINE_LEN),
    .OVERFLOW  (OVERFLOW),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Transmitter model: busy for 10 cycles after each strobe, or while forced
  always @(posedge CLK) begin
    if (WR_EN) tx_cnt <= 10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign TX_BUSY = tx_force | (tx_cnt != 0);

  // Protocol watch across every scenario
  always @(posedge CLK) begin
    if (WR_EN === 1'b1) begin
      wr_count++;
      checks++;
      if (prev_wr !== 1'b0 || prev_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wr_en_protocol: WR_EN=1 with previous WR_EN=%b TX_BUSY=%b, required both 0", prev_wr, prev_busy);
      end
    end
    if (READY_CLR === 1'b1) begin
      rc_count++;
      checks++;
      if (BUSY !== 1'b0 || WR_EN !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_clr_protocol: READY_CLR=1 with BUSY=%b WR_EN=%b, required both 0", BUSY, WR_EN);
      end
    end
    prev_wr   = WR_EN;
    prev_busy = TX_BUSY;
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit got;
    ok       = 1'b0;
    RX_DATA  = b;
    RX_READY = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      got = (READY_CLR === 1'b1);
      @(negedge CLK);
      if (got) begin
        ok = 1'b1;
        break;
      end
    end
    RX_READY = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_tx(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (WR_EN === 1'b1) begin
        d  = TX_DATA;
        ok = 1'b1;
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST      = 1'b1;
    RX_READY = 1'b0;
    RX_DATA  = 8'h00;
    tx_force = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    checks += 6;
    if (WR_EN !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wr_en: got %b, required 0", WR_EN); end
    if (READY_CLR !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_clr: got %b, required 0", READY_CLR); end
    if (TX_DATA !== 8'h00)  begin errors++; $display("[TB] FAIL reset_tx_data: got %h, required 00", TX_DATA); end
    if (LINE_LEN !== '0)    begin errors++; $display("[TB] FAIL reset_line_len: got %0d, required 0", LINE_LEN); end
    if (OVERFLOW !== 1'b0)  begin errors++; $display("[TB] FAIL reset_overflow: got %b, required 0", OVERFLOW); end
    if (BUSY !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", BUSY); end
  endtask

  task automatic test_basic_line();
    bit ok;
    logic [7:0] d, e;
    logic [7:0] msg [3];
    int wr0;
    msg[0] = 8'h41; msg[1] = 8'h62; msg[2] = 8'h43;
    wr0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(msg[i]);
      send_byte(msg[i], ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL basic_rx: byte %h not consumed, required READY_CLR", msg[i]); end
    end
    checks++;
    if (LINE_LEN !== LW'(3)) begin errors++; $display("[TB] FAIL basic_len_before: got %0d, required 3", LINE_LEN); end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_byte(8'h0D, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tx(d, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL basic_tx: no WR_EN, required byte %h", e);
        exp_q.delete();
      end else if (d !== e) begin
        errors++; $display("[TB] FAIL basic_tx: TX_DATA=%h, required %h", d, e);
      end
    end
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("[TB] FAIL basic_idle: BUSY=%b, required 0", BUSY); end
    if (LINE_LEN !== '0) begin errors++; $display("[TB] FAIL basic_len_after: got %0d, required 0", LINE_LEN); end
    if (wr_count - wr0 != 5) begin errors++; $display("[TB] FAIL basic_pulses: got %0d WR_EN pulses, required 5", wr_count - wr0); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] d, e;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) exp_q.push_back(8'(8'h30 + i));
      send_byte(8'(8'h30 + i), ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL ovf_rx: byte %0d not consumed, required READY_CLR", i); end
      if (i == DEPTH - 1) begin
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: OVERFLOW=%b after byte %0d, required 0", OVERFLOW, i + 1); end
      end
      if (i == DEPTH) begin
        checks++;
        if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: OVERFLOW=%b after byte %0d, required 1", OVERFLOW, i + 1); end
      end
    end
    checks++;
    if (LINE_LEN !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL ovf_len: got %0d, required %0d", LINE_LEN, DEPTH); end
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_byte(8'h0D, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tx(d, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL ovf_tx: no WR_EN, required byte %h", e);
        exp_q.delete();
      end else if (d !== e) begin
        errors++; $display("[TB] FAIL ovf_tx: TX_DATA=%h, required %h", d, e);
      end
    end
    wait_idle(ok);
    checks += 2;
    if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: OVERFLOW=%b, required 0", OVERFLOW); end
    if (LINE_LEN !== '0)   begin errors++; $display("[TB] FAIL ovf_len_after: got %0d, required 0", LINE_LEN); end
  endtask

  task automatic test_empty_line();
    bit ok;
    logic [7:0] d, e;
    send_byte(8'h0A, ok);
    checks += 2;
    if (LINE_LEN !== '0) begin errors++; $display("[TB] FAIL lf_len: got %0d, required 0", LINE_LEN); end
    if (BUSY !== 1'b0)   begin errors++; $display("[TB] FAIL lf_busy: got %b, required 0", BUSY); end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_byte(8'h0D, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tx(d, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL empty_tx: no WR_EN, required byte %h", e);
        exp_q.delete();
      end else if (d !== e) begin
        errors++; $display("[TB] FAIL empty_tx: TX_DATA=%h, required %h", d, e);
      end
    end
    wait_idle(ok);
    repeat (12) @(negedge CLK);
    checks++;
    if (WR_EN !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("[TB] FAIL empty_extra: WR_EN=%b BUSY=%b, required 0 0", WR_EN, BUSY); end
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    logic [7:0] d, e;
    int wr0;
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h79);
    send_byte(8'h78, ok);
    send_byte(8'h79, ok);
    send_byte(8'h7A, ok);
    send_byte(8'h0D, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tx(d, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL rst_mid_tx: no WR_EN, required byte %h", e);
        exp_q.delete();
      end else if (d !== e) begin
        errors++; $display("[TB] FAIL rst_mid_tx: TX_DATA=%h, required %h", d, e);
      end
    end
    // Returned in GUARD after the second strobe; the next cycle is DRAIN
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    wr0 = wr_count;
    checks += 5;
    if (WR_EN !== 1'b0 || READY_CLR !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_strobes: WR_EN=%b READY_CLR=%b, required 0 0", WR_EN, READY_CLR); end
    if (TX_DATA !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_tx_data: got %h, required 00", TX_DATA); end
    if (LINE_LEN !== '0)   begin errors++; $display("[TB] FAIL rst_mid_len: got %0d, required 0", LINE_LEN); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_overflow: got %b, required 0", OVERFLOW); end
    if (BUSY !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_busy: got %b, required 0", BUSY); end
    repeat (40) @(negedge CLK);
    checks++;
    if (wr_count != wr0) begin errors++; $display("[TB] FAIL rst_mid_no_wr: got %0d WR_EN pulses, required 0", wr_count - wr0); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    logic [7:0] d, e;
    int wr0, rc0;
    exp_q.push_back(8'h71);
    send_byte(8'h71, ok);
    tx_force = 1'b1;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_byte(8'h0D, ok);
    RX_DATA  = 8'h55;
    RX_READY = 1'b1;
    wr0 = wr_count;
    rc0 = rc_count;
    repeat (50) @(negedge CLK);
    checks++;
    if (wr_count != wr0) begin errors++; $display("[TB] FAIL hold_no_wr: got %0d WR_EN pulses while busy, required 0", wr_count - wr0); end
    tx_force = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tx(d, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL hold_tx: no WR_EN, required byte %h", e);
        exp_q.delete();
      end else if (d !== e) begin
        errors++; $display("[TB] FAIL hold_tx: TX_DATA=%h, required %h", d, e);
      end
    end
    checks += 2;
    if (rc_count != rc0) begin errors++; $display("[TB] FAIL hold_rc_early: got %0d READY_CLR pulses during tx, required 0", rc_count - rc0); end
    wait_idle(ok);
    if (!ok) begin errors++; $display("[TB] FAIL hold_idle: BUSY=%b, required 0", BUSY); end
    repeat (6) @(negedge CLK);
    checks += 2;
    if (rc_count - rc0 != 1) begin errors++; $display("[TB] FAIL hold_rc_once: got %0d READY_CLR pulses, required 1", rc_count - rc0); end
    if (LINE_LEN !== LW'(1)) begin errors++; $display("[TB] FAIL hold_len: got %0d, required 1", LINE_LEN); end
    RX_READY = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wr_count  = 0;
    rc_count  = 0;
    tx_cnt    = 0;
    prev_wr   = 1'b0;
    prev_busy = 1'b0;
    RST       = 1'b1;
    RX_READY  = 1'b0;
    RX_DATA   = 8'h00;
    tx_force  = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic_line();
    test_overflow();
    test_empty_line();
    test_reset_mid_tx();
    test_busy_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_line_echo.md
UART_LINE_ECHO -- requirements
Module: uart_line_echo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, line buffer capacity in bytes (power of two, 4..64).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port RX_READY  input  1  receiver holds a valid byte.
REQ-005 SHALL have port RX_DATA  input  8  received byte, valid while RX_READY=1.
REQ-006 SHALL have port READY_CLR  output  1  one-cycle pulse that consumes the current receiver byte.
REQ-007 SHALL have port TX_BUSY  input  1  transmitter busy.
REQ-008 SHALL have port TX_DATA  output  8  byte offered to the transmitter.
REQ-009 SHALL have port WR_EN  output  1  one-cycle transmit strobe.
REQ-010 SHALL have port LINE_LEN  output  $clog2(DEPTH)+1  bytes currently buffered.
REQ-011 SHALL have port OVERFLOW  output  1  sticky flag: current line exceeded DEPTH.
REQ-012 SHALL have port BUSY  output  1  high whenever the state is not COLLECT.

Function
REQ-013 SHALL implement states COLLECT, LOAD, STROBE, GUARD and DRAIN.
REQ-014 In COLLECT with RX_READY=1, SHALL pulse READY_CLR for exactly one cycle and capture RX_DATA on the same edge.
REQ-015 SHALL NOT pulse READY_CLR again until RX_READY has been sampled low, or until one cycle after the previous pulse, whichever comes later.
REQ-016 Captured byte other than 0x0D or 0x0A with LINE_LEN<DEPTH: SHALL write the byte at index LINE_LEN and increment LINE_LEN.
REQ-017 Captured byte with LINE_LEN==DEPTH: SHALL discard the byte and set OVERFLOW; LINE_LEN SHALL stay at DEPTH.
REQ-018 Captured 0x0A: SHALL consume and discard it; no state change.
REQ-019 Captured 0x0D: SHALL go to LOAD on the next cycle with the transmit index at 0.
REQ-020 Transmit sequence: buffer[0..LINE_LEN-1] in order, then 0x21 ('!') only if OVERFLOW=1, then 0x0D, then 0x0A.
REQ-021 LOAD: SHALL drive TX_DATA with the next sequence byte; if TX_BUSY=0, SHALL go to STROBE.
REQ-022 STROBE: SHALL assert WR_EN for exactly one cycle with TX_DATA stable; next state is GUARD.
REQ-023 GUARD: SHALL last exactly one cycle and ignore TX_BUSY; next state is DRAIN.
REQ-024 DRAIN: when TX_BUSY=0, SHALL advance the index and go to LOAD, or go to COLLECT after the 0x0A byte.
REQ-025 TX_DATA SHALL hold its value from LOAD until the next LOAD.
REQ-026 On return to COLLECT, SHALL clear LINE_LEN and OVERFLOW in the same cycle.
REQ-027 Outside COLLECT, SHALL NOT assert READY_CLR; a pending receiver byte SHALL be consumed only after the return to COLLECT.
REQ-028 A line containing only 0x0D SHALL transmit exactly 0x0D, 0x0A.
REQ-029 Minimum cost per transmitted byte with TX_BUSY always low SHALL be 4 cycles (LOAD, STROBE, GUARD, DRAIN).
REQ-030 WR_EN and READY_CLR SHALL never be high in the same cycle.

Reset
REQ-031 With RST=1 at a clock edge, SHALL enter COLLECT, drive WR_EN=0, READY_CLR=0, TX_DATA=0x00, LINE_LEN=0, OVERFLOW=0 and BUSY=0.
REQ-032 Reset in any state, including mid-transmission, SHALL abandon the line with no further WR_EN pulse; buffer contents need not be cleared.
REQ-033 RST SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Scenario: receive 'A','b','C',0x0D with TX_BUSY modelled 10 cycles after each WR_EN -> four... SHALL see exactly five WR_EN pulses with TX_DATA 0x41, 0x62, 0x43, 0x0D, 0x0A; LINE_LEN 3 before, 0 after; BUSY low at end.
REQ-035 Scenario: receive DEPTH+2 = 18 bytes 0x30..0x41 then 0x0D -> OVERFLOW=1 after byte 17; transmit 0x30..0x3F, 0x21, 0x0D, 0x0A; OVERFLOW=0 after the final byte.
REQ-036 Scenario: receive 0x0A, 0x0D -> no buffer write; transmit only 0x0D, 0x0A.
REQ-037 Scenario: assert RST for one cycle during DRAIN of the second byte of "xyz\r" -> no WR_EN afterwards; all outputs at reset values one cycle later.
REQ-038 Scenario: hold TX_BUSY=1 for 50 cycles at entry to LOAD -> WR_EN stays 0 until TX_BUSY=0; hold RX_READY=1 with 0x55 during transmission -> no READY_CLR until BUSY=0, then exactly one READY_CLR pulse.
REQ-039 Scenario: all scenarios -> bench assertion that WR_EN never lasts more than one cycle and WR_EN is never asserted while TX_BUSY=1 in the preceding cycle.
